// File: rtl/smpl_iter_ctrl.sv
// Sample iteration controller: latches one triangle and its bounding box, then
// walks the box in raster order at the selected MSAA step, one sample per transfer.
module smpl_iter_ctrl #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S    [VERTS-1:0][AXIS-1:0],
    input  logic        [SIGFIG-1:0] color_R13U  [COLORS-1:0],
    input  logic signed [SIGFIG-1:0] box_R13S    [1:0][1:0],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    input  logic                     stall_R14H,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S    [VERTS-1:0][AXIS-1:0],
    output logic        [SIGFIG-1:0] color_R14U  [COLORS-1:0],
    output logic signed [SIGFIG-1:0] sample_R14S [1:0],
    output logic                     validSamp_R14H
);

    typedef enum logic {WAIT, TEST} state_t;

    state_t                   state_q, state_d;
    logic signed [SIGFIG-1:0] tri_q    [VERTS-1:0][AXIS-1:0];
    logic signed [SIGFIG-1:0] tri_d    [VERTS-1:0][AXIS-1:0];
    logic        [SIGFIG-1:0] color_q  [COLORS-1:0];
    logic        [SIGFIG-1:0] color_d  [COLORS-1:0];
    logic signed [SIGFIG-1:0] box_q    [1:0][1:0];
    logic signed [SIGFIG-1:0] box_d    [1:0][1:0];
    logic signed [SIGFIG-1:0] sample_q [1:0];
    logic signed [SIGFIG-1:0] sample_d [1:0];
    logic signed [SIGFIG-1:0] step_q, step_d;

    // Illegal (non-one-hot) selects fall back to the 1x step.
    function automatic logic signed [SIGFIG-1:0] step_of(input logic [3:0] ss);
        logic signed [SIGFIG-1:0] one;
        one = {{(SIGFIG-1){1'b0}}, 1'b1};
        case (ss)
            4'b1000: step_of = one <<< RADIX;
            4'b0100: step_of = one <<< (RADIX - 1);
            4'b0010: step_of = one <<< (RADIX - 2);
            4'b0001: step_of = one <<< (RADIX - 3);
            default: step_of = one <<< RADIX;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        tri_d    = tri_q;
        color_d  = color_q;
        box_d    = box_q;
        step_d   = step_q;
        sample_d = sample_q;
        case (state_q)
            WAIT: begin
                if (validTri_R13H) begin
                    tri_d       = tri_R13S;
                    color_d     = color_R13U;
                    box_d       = box_R13S;
                    step_d      = step_of(subSample_RnnnnU);
                    sample_d[0] = box_R13S[0][0];
                    sample_d[1] = box_R13S[0][1];
                    state_d     = TEST;
                end
            end
            TEST: begin
                // Valid is implied by TEST, so a transfer is simply "not stalled".
                if (!stall_R14H) begin
                    if (sample_q[0] < box_q[1][0]) begin
                        sample_d[0] = sample_q[0] + step_q;
                    end else if (sample_q[1] < box_q[1][1]) begin
                        sample_d[0] = box_q[0][0];
                        sample_d[1] = sample_q[1] + step_q;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= WAIT;
            tri_q    <= '{default: '{default: '0}};
            color_q  <= '{default: '0};
            sample_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            sample_q <= sample_d;
        end
    end

    // Box and step are only consulted in TEST, after an accept has loaded them.
    always_ff @(posedge clk) begin
        box_q  <= box_d;
        step_q <= step_d;
    end

    assign halt_RnnnnL    = (state_q == WAIT);
    assign validSamp_R14H = (state_q == TEST);
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = sample_q;

endmodule

// File: tb/tb_smpl_iter_ctrl.sv
// Testbench for smpl_iter_ctrl: table of boxes checked through a sample scoreboard,
// plus directed stall, reset and back-to-back triangle sequences.
module tb_smpl_iter_ctrl;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic                     clk;
    logic                     rst;
    logic signed [SIGFIG-1:0] tri_in   [VERTS-1:0][AXIS-1:0];
    logic        [SIGFIG-1:0] col_in   [COLORS-1:0];
    logic signed [SIGFIG-1:0] box_in   [1:0][1:0];
    logic                     valid_tri;
    logic        [3:0]        sub_in;
    logic                     stall;
    logic                     halt;
    logic signed [SIGFIG-1:0] tri_out  [VERTS-1:0][AXIS-1:0];
    logic        [SIGFIG-1:0] col_out  [COLORS-1:0];
    logic signed [SIGFIG-1:0] samp_out [1:0];
    logic                     valid_samp;

    smpl_iter_ctrl #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (col_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_tri),
        .subSample_RnnnnU (sub_in),
        .stall_R14H       (stall),
        .halt_RnnnnL      (halt),
        .tri_R14S         (tri_out),
        .color_R14U       (col_out),
        .sample_R14S      (samp_out),
        .validSamp_R14H   (valid_samp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [SIGFIG-1:0] llx, lly, urx, ury;
        logic [3:0]               sub;
        int                       seed;
        int                       exp_cnt;
        logic signed [SIGFIG-1:0] lastx, lasty;
        bit                       stall_en;
    } vec_t;

    typedef struct {
        logic signed [SIGFIG-1:0] x, y;
        int                       seed;
        bit                       last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   xfer_cnt = 0;
    int   ncyc     = 0;
    int   rise_cyc = 0;
    int   last_cyc = 0;
    bit   prev_v   = 1'b0;
    logic signed [SIGFIG-1:0] last_x, last_y;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic signed [SIGFIG-1:0] mk_tri(input int s, input int v, input int a);
        return SIGFIG'(s * 100 + v * 10 + a - 50);
    endfunction

    function automatic logic [SIGFIG-1:0] mk_col(input int s, input int c);
        return SIGFIG'(s * 7 + c + 256);
    endfunction

    function automatic int step_for(input logic [3:0] sub);
        case (sub)
            4'b1000: return 1024;
            4'b0100: return 512;
            4'b0010: return 256;
            default: return 128;
        endcase
    endfunction

    // Sample monitor: checks every transferred sample against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   bad;
        ncyc++;
        if (rst) begin
            chk("halt_vs_valid", halt, !valid_samp);
            if (valid_samp && !prev_v) rise_cyc = ncyc;
            if (valid_samp && !stall) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got (%0d,%0d) required none", samp_out[0], samp_out[1]);
                end else begin
                    e = sb.pop_front();
                    chk("sample_x", samp_out[0], e.x);
                    chk("sample_y", samp_out[1], e.y);
                    bad = 0;
                    for (int v = 0; v < VERTS; v++)
                        for (int a = 0; a < AXIS; a++)
                            if (tri_out[v][a] !== mk_tri(e.seed, v, a)) bad++;
                    for (int c = 0; c < COLORS; c++)
                        if (col_out[c] !== mk_col(e.seed, c)) bad++;
                    chk("tri_color_words_wrong", bad, 0);
                    xfer_cnt++;
                    last_x = samp_out[0];
                    last_y = samp_out[1];
                    if (e.last) last_cyc = ncyc;
                end
            end
        end
        prev_v = valid_samp;
    end

    task automatic load(input vec_t v);
        for (int i = 0; i < VERTS; i++)
            for (int a = 0; a < AXIS; a++) tri_in[i][a] = mk_tri(v.seed, i, a);
        for (int c = 0; c < COLORS; c++) col_in[c] = mk_col(v.seed, c);
        box_in[0][0] = v.llx;
        box_in[0][1] = v.lly;
        box_in[1][0] = v.urx;
        box_in[1][1] = v.ury;
        sub_in = v.sub;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        int   step;
        step = step_for(v.sub);
        for (int y = int'(v.lly); y <= int'(v.ury); y += step)
            for (int x = int'(v.llx); x <= int'(v.urx); x += step) begin
                e.x    = SIGFIG'(x);
                e.y    = SIGFIG'(y);
                e.seed = v.seed;
                e.last = (x == int'(v.urx)) && (y == int'(v.ury));
                sb.push_back(e);
            end
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 200 && !halt; k++) begin
            @(posedge clk); #1;
        end
        if (!halt) chk("ready_timeout", halt, 1);
    endtask

    task automatic drain(input bit stall_en);
        int k;
        for (k = 0; k < 1000 && sb.size() != 0; k++) begin
            stall = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        if (sb.size() != 0) chk("drain_timeout_left", sb.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int c0;
        wait_ready();
        load(v);
        push_exp(v);
        c0 = xfer_cnt;
        valid_tri = 1'b1;
        @(posedge clk); #1;
        valid_tri = 1'b0;
        drain(v.stall_en);
        chk({tag, "_count"}, xfer_cnt - c0, v.exp_cnt);
        chk({tag, "_last_x"}, last_x, v.lastx);
        chk({tag, "_last_y"}, last_y, v.lasty);
        chk({tag, "_halt_after"}, halt, 1);
        chk({tag, "_valid_after"}, valid_samp, 0);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t va, vb;
        int   a_last;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t vs, va, vb;
        int   a_last;
        int   k;

        tbl[0] = '{24'sh800, 24'shC00, 24'sh800, 24'shC00, 4'b1000, 1, 1, 24'sh800, 24'shC00, 1'b0};
        tbl[1] = '{24'sh0, 24'sh0, 24'sh400, 24'sh400, 4'b1000, 2, 4, 24'sh400, 24'sh400, 1'b0};
        tbl[2] = '{24'sh0, 24'sh0, 24'sh400, 24'sh400, 4'b0100, 3, 9, 24'sh400, 24'sh400, 1'b0};
        tbl[3] = '{-24'sd1024, -24'sd1024, 24'sh0, 24'sh0, 4'b1000, 4, 4, 24'sh0, 24'sh0, 1'b0};
        tbl[4] = '{24'sh0, 24'sh0, 24'sh100, 24'sh80, 4'b0001, 5, 6, 24'sh100, 24'sh80, 1'b0};
        tbl[5] = '{24'sh400, 24'sh0, 24'sh1000, 24'sh100, 4'b0010, 6, 26, 24'sh1000, 24'sh100, 1'b1};
        tbl[6] = '{-24'sd2048, 24'sh400, 24'sh800, 24'shC00, 4'b0100, 7, 45, 24'sh800, 24'shC00, 1'b1};
        tbl[7] = '{24'sh0, 24'sh0, 24'sh0, 24'sh800, 4'b1000, 8, 3, 24'sh0, 24'sh800, 1'b0};

        rst       = 1'b0;
        valid_tri = 1'b0;
        stall     = 1'b0;
        sub_in    = 4'b1000;
        load(tbl[1]);
        #2;
        chk("rst_halt", halt, 1);
        chk("rst_valid", valid_samp, 0);
        chk("rst_sample_x", samp_out[0], 0);
        chk("rst_sample_y", samp_out[1], 0);
        chk("rst_tri00", tri_out[0][0], 0);
        chk("rst_color0", col_out[0], 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Stall for three cycles while the second sample is presented.
        wait_ready();
        vs = tbl[1];
        vs.seed = 9;
        load(vs);
        push_exp(vs);
        k = xfer_cnt;
        valid_tri = 1'b1;
        @(posedge clk); #1;
        valid_tri = 1'b0;
        @(posedge clk); #1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_hold_x", samp_out[0], 24'sh400);
            chk("stall_hold_y", samp_out[1], 0);
            chk("stall_hold_valid", valid_samp, 1);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        drain(1'b0);
        chk("stall_count", xfer_cnt - k, 4);

        // Asynchronous reset in the middle of an iteration.
        wait_ready();
        vs = tbl[6];
        vs.seed = 10;
        load(vs);
        push_exp(vs);
        valid_tri = 1'b1;
        @(posedge clk); #1;
        valid_tri = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_halt", halt, 1);
        chk("midrst_valid", valid_samp, 0);
        chk("midrst_sample_x", samp_out[0], 0);
        chk("midrst_sample_y", samp_out[1], 0);
        chk("midrst_tri21", tri_out[2][1], 0);
        chk("midrst_color2", col_out[2], 0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        run_vec(tbl[2], "after_rst");

        // Two triangles with validTri held high: second accepted after one bubble.
        wait_ready();
        va = '{24'sh0, 24'sh0, 24'sh400, 24'sh0, 4'b1000, 20, 2, 24'sh400, 24'sh0, 1'b0};
        vb = '{24'sh0, 24'sh0, 24'sh200, 24'sh200, 4'b0100, 21, 4, 24'sh200, 24'sh200, 1'b0};
        load(va);
        push_exp(va);
        k = xfer_cnt;
        valid_tri = 1'b1;
        @(posedge clk); #1;
        load(vb);
        push_exp(vb);
        a_last = -1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (halt) begin
                a_last = last_cyc;
                @(posedge clk); #1;
                valid_tri = 1'b0;
                break;
            end
        end
        valid_tri = 1'b0;
        chk("b2b_bubble_seen", (a_last >= 0), 1);
        chk("b2b_b_latched_tri", tri_out[0][0], mk_tri(21, 0, 0));
        drain(1'b0);
        chk("b2b_gap_cycles", rise_cyc - a_last, 2);
        chk("b2b_count", xfer_cnt - k, 6);
        @(posedge clk); #1;
        chk("b2b_no_third", valid_samp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
